qc_depermuter: RTL and testbench
================================

// Module: qc_depermuter
// PURPOSE
//  Inverse of the layer permuter in the QC-LDPC layered decoder datapath. Captures one layer's
//  dmax check-node result slots (Z lanes each), undoes each slot's cyclic shift, and streams the
//  re-aligned slots one per cycle, tagged with base-matrix column, toward posterior-LLR write-back.
//  Sits between the check-node unit and the column LLR storage.
// PARAMETERS
//  BITS          8           message width (5 int + 3 frac), unsigned bit-vector, not interpreted
//  Z             32          lifting size (power of 2)
//  dmax          6           max slots per layer (max 1's per base-matrix row)
//  ROW_CNT       10          base-matrix rows (layers)
//  COL_CNT       10          base-matrix columns
//  BITS_OF_LAYER $clog2(Z)   shift magnitude width; shift ports are BITS_OF_LAYER+1 bits signed
// PORTS
//  clk        in   1                       clock, rising edge
//  rst        in   1                       reset, asynchronous, active-high
//  in_valid   in   1                       layer bundle valid
//  in_ready   out  1                       bundle accepted when in_valid & in_ready
//  in_msg     in   [dmax][Z][BITS]         slot messages, in permuted (shifted) lane order
//  in_shift   in   [dmax] s(BITS_OF_LAYER+1) per-slot shift 0..Z-1; -1 = null slot (no 1 in PCM)
//  in_col     in   [dmax] $clog2(COL_CNT)  per-slot base-matrix column
//  in_layer   in   $clog2(ROW_CNT)         layer index of bundle
//  out_valid  out  1                       output slot valid
//  out_ready  in   1                       downstream accepts when out_valid & out_ready
//  out_msg    out  [Z][BITS]               de-permuted slot
//  out_col    out  $clog2(COL_CNT)         column of out_msg
//  out_layer  out  $clog2(ROW_CNT)         layer of out_msg
//  out_last   out  1                       high with final non-null slot of bundle
// BEHAVIOUR
//  - Reset (async): state IDLE, in_ready=1, out_valid=0, out_msg/out_col/out_layer/out_last=0,
//    slot counter=0, capture buffer cleared.
//  - FSM IDLE: in_ready=1. On in_valid&in_ready capture in_msg/in_shift/in_col/in_layer into
//    buffer, compute last_idx = highest slot with shift>=0, go RUN at slot 0. All-null bundle:
//    captured, no output, stays IDLE (in_ready stays 1).
//  - RUN: in_ready=0. Output register (1 stage) loads when empty or out_ready&out_valid.
//    Non-null slot k loads out_msg[z] = buf_msg[k][(z - shift_k) mod Z] (right rotation by
//    shift_k, exact inverse of permuter's out[z]=in[(z+s) mod Z]); out_col=buf_col[k],
//    out_layer=buf_layer, out_last=(k==last_idx); out_valid=1.
//  - Null slot handling per CONFIGURATION.
//  - After loading slot last_idx -> DRAIN: wait until out_valid&out_ready, then IDLE. Next bundle
//    accepted the cycle after that handshake (in_ready=1 in IDLE), never earlier.
//  - Latency: bundle handshake at cycle T -> first out_valid at T+2 (first slot non-null).
//    Throughput 1 slot/cycle with out_ready held 1.
//  - Backpressure: out_ready=0 freezes out_msg/out_col/out_layer/out_last and slot counter;
//    out_valid never drops without handshake.
//  - Shift arithmetic: (z - s) mod Z via BITS_OF_LAYER-bit wrap; s=0 is pass-through; s=Z-1 valid.
//  - in_valid while RUN/DRAIN ignored (in_ready=0); upstream must hold bundle.
//  - rst mid-bundle: bundle discarded, outputs to reset values, no partial out_last.
// CONFIGURATION
//  QC_DEPERM_SKIP_NULL_EN defined: priority encoder selects next non-null slot; null slots
//    consume zero cycles (bundle with n non-null slots emits in n cycles at out_ready=1).
//  Not defined: slot counter steps every slot; a null slot costs one cycle with out_valid=0 (when
//    register drained) -> bundle always takes dmax cycles from first slot.
// TESTING (Z=32, dmax=6, BITS=8)
//  - Reset mid-RUN at slot 2 -> out_valid=0, in_ready=1 next cycle, no further output for bundle.
//  - Slot0 msg lane z = z, shift=5, other slots null -> out_msg[z]=(z-5) mod 32 (lane 0 = 27),
//    out_last=1, out_col=in_col[0], first out_valid 2 cycles after accept.
//  - Shifts {0,1,31,16,-1,7}, out_ready=1 -> 5 outputs with correct rotations, out_last on slot 5;
//    SKIP_NULL_EN: 5 consecutive valid cycles; without: 1 idle cycle between slot 3 and 5.
//  - Round-trip: random msgs through permuter then qc_depermuter with same shifts -> bit-exact.
//  - out_ready toggled 1/0 each cycle -> outputs held stable while stalled, order intact,
//    in_ready stays 0 until final handshake, then 1.
//  - All six shifts = -1 -> no out_valid, in_ready=1 throughout; next bundle accepted next cycle.

Source files
------------

// File: rtl/qc_depermuter.sv
// Inverse layer permuter: captures a layer's slots, undoes each slot's cyclic shift and streams them out.
// Optional QC_DEPERM_SKIP_NULL_EN: null slots are skipped by a priority encoder instead of costing a cycle.
module qc_depermuter #(
    parameter int BITS          = 8,
    parameter int Z             = 32,
    parameter int DMAX          = 6,
    parameter int ROW_CNT       = 10,
    parameter int COL_CNT       = 10,
    parameter int BITS_OF_LAYER = $clog2(Z)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [DMAX-1:0][Z-1:0][BITS-1:0]             in_msg,
    input  logic [DMAX-1:0][BITS_OF_LAYER:0]             in_shift,
    input  logic [DMAX-1:0][$clog2(COL_CNT)-1:0]         in_col,
    input  logic [$clog2(ROW_CNT)-1:0]                   in_layer,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [Z-1:0][BITS-1:0]                       out_msg,
    output logic [$clog2(COL_CNT)-1:0]                   out_col,
    output logic [$clog2(ROW_CNT)-1:0]                   out_layer,
    output logic                                         out_last
);
    localparam int BL = BITS_OF_LAYER;
    localparam int CW = $clog2(DMAX + 1);
    localparam int COLW = $clog2(COL_CNT);
    localparam int LAYW = $clog2(ROW_CNT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                                state_q, state_d;
    logic [DMAX-1:0][Z-1:0][BITS-1:0]      msg_q, msg_d;
    logic [DMAX-1:0][BL:0]                 shift_q, shift_d;
    logic [DMAX-1:0][COLW-1:0]             col_q, col_d;
    logic [LAYW-1:0]                       layer_q, layer_d;
    logic [CW-1:0]                         last_q, last_d;
    logic [CW-1:0]                         cnt_q, cnt_d;
    logic                                  ovalid_q, ovalid_d;
    logic [Z-1:0][BITS-1:0]                omsg_q, omsg_d;
    logic [COLW-1:0]                       ocol_q, ocol_d;
    logic [LAYW-1:0]                       olayer_q, olayer_d;
    logic                                  olast_q, olast_d;

    logic [CW-1:0]                         in_last, sel;
    logic                                  in_any, sel_nn, can_load;
    logic [Z-1:0][BITS-1:0]                sel_msg, rot;
    logic [BL-1:0]                         sel_sh;

    // Highest non-null slot of the incoming bundle; negative shift marks a null slot.
    always_comb begin
        in_last = '0;
        in_any  = 1'b0;
        for (int i = 0; i < DMAX; i++) begin
            if (!in_shift[i][BL]) begin
                in_last = CW'(i);
                in_any  = 1'b1;
            end
        end
    end

    always_comb begin
`ifdef QC_DEPERM_SKIP_NULL_EN
        sel = last_q;
        for (int i = DMAX - 1; i >= 0; i--) begin
            if (i >= int'(cnt_q) && !shift_q[i][BL]) sel = CW'(i);
        end
`else
        sel = cnt_q;
`endif
    end

    assign sel_nn   = !shift_q[sel][BL];
    assign sel_msg  = msg_q[sel];
    assign sel_sh   = shift_q[sel][BL-1:0];
    assign can_load = !ovalid_q || out_ready;

    // Right rotation; the lane index wraps naturally because Z is a power of two.
    for (genvar z = 0; z < Z; z++) begin : g_rot
        logic [BL-1:0] src;
        assign src    = BL'(z) - sel_sh;
        assign rot[z] = sel_msg[src];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            msg_q    <= '0;
            shift_q  <= '0;
            col_q    <= '0;
            layer_q  <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
            ovalid_q <= 1'b0;
            omsg_q   <= '0;
            ocol_q   <= '0;
            olayer_q <= '0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            shift_q  <= shift_d;
            col_q    <= col_d;
            layer_q  <= layer_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            ovalid_q <= ovalid_d;
            omsg_q   <= omsg_d;
            ocol_q   <= ocol_d;
            olayer_q <= olayer_d;
            olast_q  <= olast_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid && in_any) state_d = RUN;
            RUN:     if (can_load && sel_nn && sel == last_q) state_d = DRAIN;
            DRAIN:   if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        msg_d    = msg_q;
        shift_d  = shift_q;
        col_d    = col_q;
        layer_d  = layer_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        ovalid_d = ovalid_q;
        omsg_d   = omsg_q;
        ocol_d   = ocol_q;
        olayer_d = olayer_q;
        olast_d  = olast_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    msg_d   = in_msg;
                    shift_d = in_shift;
                    col_d   = in_col;
                    layer_d = in_layer;
                    last_d  = in_last;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (can_load) begin
                    cnt_d = sel + 1'b1;
                    if (sel_nn) begin
                        ovalid_d = 1'b1;
                        omsg_d   = rot;
                        ocol_d   = col_q[sel];
                        olayer_d = layer_q;
                        olast_d  = (sel == last_q);
                    end else begin
                        ovalid_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) ovalid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = ovalid_q;
        out_msg   = omsg_q;
        out_col   = ocol_q;
        out_layer = olayer_q;
        out_last  = olast_q;
    end

endmodule

// File: tb/tb_qc_depermuter.sv
// Bench for qc_depermuter: random data is permuted by a reference permuter, then must come back bit-exact.
module tb_qc_depermuter;
    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [5:0][31:0][7:0]     in_msg = '0;
    logic [5:0][5:0]           in_shift = '0;
    logic [5:0][3:0]           in_col = '0;
    logic [3:0]                in_layer = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b1;
    logic [31:0][7:0]          out_msg;
    logic [3:0]                out_col;
    logic [3:0]                out_layer;
    logic                      out_last;

    int total = 0;
    int bad = 0;

    int                  sh [6];
    logic [5:0][31:0][7:0] dsl;
    logic [255:0]        exp_msg [$];
    logic [3:0]          exp_col [$];
    logic                exp_last [$];
    int                  nexp;

    qc_depermuter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_msg(in_msg), .in_shift(in_shift), .in_col(in_col), .in_layer(in_layer),
        .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
        .out_col(out_col), .out_layer(out_layer), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Build a bundle: original slot data, permuted as the upstream permuter would (out[z]=in[(z+s)%Z]).
    task automatic prep(input bit lanez);
        int lastk;
        exp_msg.delete(); exp_col.delete(); exp_last.delete();
        lastk = -1;
        for (int k = 0; k < 6; k++) if (sh[k] >= 0) lastk = k;
        for (int k = 0; k < 6; k++)
            for (int j = 0; j < 32; j++)
                dsl[k][j] = (lanez && k == 0) ? 8'((j - sh[k]) & 31) : 8'($urandom_range(0, 255));
        for (int k = 0; k < 6; k++) begin
            for (int z = 0; z < 32; z++)
                in_msg[k][z] = (sh[k] >= 0) ? dsl[k][(z + sh[k]) % 32] : 8'($urandom_range(0, 255));
            in_shift[k] = 6'(sh[k]);
            in_col[k]   = 4'($urandom_range(0, 9));
        end
        in_layer = 4'($urandom_range(0, 9));
        for (int k = 0; k < 6; k++) begin
            if (sh[k] >= 0) begin
                exp_msg.push_back(dsl[k]);
                exp_col.push_back(in_col[k]);
                exp_last.push_back(k == lastk);
            end
        end
        nexp = exp_msg.size();
    endtask

    task automatic run(input bit tog, output int first, output int lastc);
        int cyc, got;
        bit hold;
        logic [255:0] hm;
        logic [8:0] hs;
        chk("accept_ready", 256'(in_ready), 256'(1));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0; got = 0; first = -1; lastc = -1; hold = 1'b0;
        while (got < nexp && cyc < 60) begin
            out_ready = tog ? (cyc % 2 == 1) : 1'b1;
            if (hold) begin
                chk("hold_valid", 256'(out_valid), 256'(1));
                chk("hold_msg", out_msg, hm);
                chk("hold_side", 256'({out_col, out_layer, out_last}), 256'(hs));
                hold = 1'b0;
            end
            chk("busy_ready", 256'(in_ready), 256'(0));
            if (out_valid) begin
                if (first < 0) first = cyc;
                lastc = cyc;
                if (out_ready) begin
                    chk("msg", out_msg, exp_msg[got]);
                    chk("col", 256'(out_col), 256'(exp_col[got]));
                    chk("layer", 256'(out_layer), 256'(in_layer));
                    chk("last", 256'(out_last), 256'(exp_last[got]));
                    got++;
                end else begin
                    hold = 1'b1;
                    hm = out_msg;
                    hs = {out_col, out_layer, out_last};
                end
            end
            tick();
            cyc++;
        end
        chk("slot_count", 256'(got), 256'(nexp));
        chk("idle_ready", 256'(in_ready), 256'(1));
        chk("idle_valid", 256'(out_valid), 256'(0));
        out_ready = 1'b1;
    endtask

    initial begin
        int f, l, lead;
        bit tog, any;
        tick(); tick();
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_ready", 256'(in_ready), 256'(1));
        chk("rst_msg", out_msg, 256'(0));
        chk("rst_side", 256'({out_col, out_layer, out_last}), 256'(0));
        rst = 1'b0;
        tick();

        // Single non-null slot with identity lane data, shift 5.
        sh = '{5, -1, -1, -1, -1, -1};
        prep(1'b1);
        run(1'b0, f, l);
        chk("single_first", 256'(f), 256'(1));

        // Mixed shifts with one null slot in the middle.
        sh = '{0, 1, 31, 16, -1, 7};
        prep(1'b0);
        run(1'b0, f, l);
        chk("mixed_first", 256'(f), 256'(1));
`ifdef QC_DEPERM_SKIP_NULL_EN
        chk("mixed_lastcyc", 256'(l), 256'(5));
`else
        chk("mixed_lastcyc", 256'(l), 256'(6));
`endif

        // Same shifts with out_ready toggling each cycle.
        prep(1'b0);
        run(1'b1, f, l);

        // All-null bundle is swallowed; next bundle is accepted right away.
        sh = '{-1, -1, -1, -1, -1, -1};
        prep(1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("null_ready", 256'(in_ready), 256'(1));
        chk("null_valid", 256'(out_valid), 256'(0));
        sh = '{3, 9, -1, 30, 2, -1};
        prep(1'b0);
        run(1'b0, f, l);
        chk("after_null_first", 256'(f), 256'(1));

        // Random bundles.
        for (int b = 0; b < 20; b++) begin
            any = 1'b0;
            for (int k = 0; k < 6; k++) begin
                sh[k] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 31));
                if (sh[k] >= 0) any = 1'b1;
            end
            if (!any) sh[$urandom_range(0, 5)] = int'($urandom_range(0, 31));
            lead = 0;
            while (sh[lead] < 0) lead++;
            tog = 1'($urandom_range(0, 1));
            prep(1'b0);
            run(tog, f, l);
`ifdef QC_DEPERM_SKIP_NULL_EN
            chk("rand_first", 256'(f), 256'(1));
`else
            chk("rand_first", 256'(f), 256'(1 + lead));
`endif
        end

        // Reset while slot 2 is presented.
        sh = '{4, 8, 12, 16, 20, 24};
        prep(1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_msg", out_msg, exp_msg[2]);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 256'(out_valid), 256'(0));
        chk("midrst_ready", 256'(in_ready), 256'(1));
        chk("midrst_msg", out_msg, 256'(0));
        chk("midrst_last", 256'(out_last), 256'(0));
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_valid", 256'(out_valid), 256'(0));
            chk("post_rst_ready", 256'(in_ready), 256'(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
